// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out bundle for uart_tx_fifo.
// A byte transfers on a rising edge where io_in_valid and io_in_ready are both 1; io_in_bits is held stable while io_in_valid waits, and io_in_ready depends only on FIFO fullness, never on io_in_valid.
interface uart_tx_fifo_if;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_in_bits;
  logic       io_txd;
  logic       io_busy;
  logic       io_txData_valid;
  logic [7:0] io_txData_bits;

  modport master (
    output io_in_valid, io_in_bits,
    input  io_in_ready, io_txd, io_busy, io_txData_valid, io_txData_bits
  );

  modport slave (
    input  io_in_valid, io_in_bits,
    output io_in_ready, io_txd, io_busy, io_txData_valid, io_txData_bits
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; frames run back-to-back while bytes are queued.
// The line output is registered and computed from the next-state values, so it lines up with the state register.
module uart_tx_fifo #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  uart_tx_fifo_if.slave io,
  output logic [1:0]   dbg_state
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        mem_q [DEPTH];

  logic full, empty, push, pop, baud_done;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = io.io_in_valid && !full;
  assign baud_done = (baud_q == DIV_M1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next-state: a finishing stop bit pops straight into START so queued frames leave no idle gap.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          bit_d  = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q] <= io.io_in_bits;
  end

  assign io.io_in_ready     = !full;
  assign io.io_txd          = txd_q;
  assign io.io_busy         = (state_q != S_IDLE) || !empty;
  assign io.io_txData_valid = (state_q == S_STOP) && baud_done;
  assign io.io_txData_bits  = shift_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: DIV=4/DEPTH=4 and DIV=1/DEPTH=2 instances checked against a frame-timing model.
module tb_uart_tx_fifo;
  localparam int MAXC = 512;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_fifo_if if_a ();
  uart_tx_fifo_if if_b ();
  logic [1:0] dbg_a, dbg_b;

  uart_tx_fifo #(.DIV(4), .DEPTH(4)) dut_a (.clock(clock), .reset(reset), .io(if_a), .dbg_state(dbg_a));
  uart_tx_fifo #(.DIV(1), .DEPTH(2)) dut_b (.clock(clock), .reset(reset), .io(if_b), .dbg_state(dbg_b));

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] src_q[$];
  int         acc_k[$];
  logic [7:0] acc_b[$];
  int         pop_k[$];

  logic [MAXC-1:0] got_line, got_pulse, got_busy, got_ready;
  logic [MAXC-1:0] exp_line, exp_pulse, exp_busy, exp_ready;
  logic [63:0]     got_pb, exp_pb;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int sel, input bit v, input logic [7:0] b);
    if (sel == 0) begin
      if_a.io_in_valid = v;
      if_a.io_in_bits  = b;
    end else begin
      if_b.io_in_valid = v;
      if_b.io_in_bits  = b;
    end
  endtask

  // Record k holds what the outputs show in the cycle after edge k.
  task automatic run(input int sel, input int ncyc, input int rst_edge, input bit gappy);
    int idx;
    bit v, rdy, acc;
    got_line = '0; got_pulse = '0; got_busy = '0; got_ready = '0; got_pb = '0;
    acc_k.delete();
    acc_b.delete();
    idx = 0;
    for (int k = 1; k <= ncyc; k++) begin
      v = (idx < src_q.size()) && (!gappy || ($urandom_range(0, 1) == 1));
      drive(sel, v, v ? src_q[idx] : 8'h00);
      rdy   = (sel == 0) ? if_a.io_in_ready : if_b.io_in_ready;
      reset = (k == rst_edge);
      acc   = v && rdy && (k != rst_edge);
      tick();
      reset = 1'b0;
      if (acc) begin
        acc_k.push_back(k);
        acc_b.push_back(src_q[idx]);
        idx++;
      end
      if (k == rst_edge) idx = src_q.size();
      got_line[k-1]  = (sel == 0) ? if_a.io_txd : if_b.io_txd;
      got_busy[k-1]  = (sel == 0) ? if_a.io_busy : if_b.io_busy;
      got_ready[k-1] = (sel == 0) ? if_a.io_in_ready : if_b.io_in_ready;
      if ((sel == 0) ? if_a.io_txData_valid : if_b.io_txData_valid) begin
        got_pulse[k-1] = 1'b1;
        got_pb = {got_pb[55:0], (sel == 0) ? if_a.io_txData_bits : if_b.io_txData_bits};
      end
    end
    drive(sel, 1'b0, 8'h00);
  endtask

  // Frame i is popped at edge p_i = max(accept_i + 1, end of frame i-1) and fills 10*div records from there.
  task automatic model(input int div, input int depth, input int ncyc, input int rst_edge);
    int e, occ, slot;
    bit live, in_frame, line;
    logic [7:0] b;
    exp_line = '0; exp_pulse = '0; exp_busy = '0; exp_ready = '0; exp_pb = '0;
    pop_k.delete();
    e = 0;
    foreach (acc_k[i]) begin
      pop_k.push_back((acc_k[i] + 1 > e) ? acc_k[i] + 1 : e);
      e = pop_k[i] + 10 * div;
    end
    for (int k = 1; k <= ncyc; k++) begin
      live = (rst_edge == 0) || (k < rst_edge);
      occ = 0; in_frame = 1'b0; line = 1'b1;
      if (live) begin
        foreach (acc_k[i]) if (acc_k[i] <= k) occ++;
        foreach (pop_k[i]) begin
          if (pop_k[i] <= k) occ--;
          if (k >= pop_k[i] && k < pop_k[i] + 10 * div) begin
            in_frame = 1'b1;
            slot = (k - pop_k[i]) / div;
            b = acc_b[i];
            line = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot-1];
            if (k == pop_k[i] + 10 * div - 1) begin
              exp_pulse[k-1] = 1'b1;
              exp_pb = {exp_pb[55:0], b};
            end
          end
        end
      end
      exp_line[k-1]  = line;
      exp_busy[k-1]  = in_frame || (occ > 0);
      exp_ready[k-1] = (occ < depth);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b1, 8'hAA);
    drive(1, 1'b1, 8'h5A);
    repeat (3) tick();
    tests_run++;
    if (if_a.io_txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got=%b exp=1", if_a.io_txd); end
    tests_run++;
    if (if_a.io_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", if_a.io_in_ready); end
    tests_run++;
    if (if_a.io_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", if_a.io_busy); end
    tests_run++;
    if (if_a.io_txData_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", if_a.io_txData_valid); end
    tests_run++;
    if (if_a.io_txData_bits !== 8'h00) begin tests_failed++; $display("FAIL reset_bits got=%h exp=00", if_a.io_txData_bits); end
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    reset = 1'b0;
    tick();
    tests_run++;
    if ({if_a.io_busy, if_b.io_busy} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_no_accept got=%b exp=00", {if_a.io_busy, if_b.io_busy});
    end
  endtask

  task automatic test_idle();
    src_q.delete();
    run(0, 100, 0, 1'b0);
    tests_run++;
    if (got_line[99:0] !== {100{1'b1}}) begin tests_failed++; $display("FAIL idle_line got=%h exp=all ones", got_line[99:0]); end
    tests_run++;
    if ((got_busy[99:0] | got_pulse[99:0] | ~got_ready[99:0]) !== '0) begin
      tests_failed++; $display("FAIL idle_flags busy=%h pulse=%h ready=%h", got_busy[99:0], got_pulse[99:0], got_ready[99:0]);
    end
  endtask

  task automatic test_single_55();
    logic [MAXC-1:0] pat;
    int j;
    src_q = '{8'h55};
    run(0, 60, 0, 1'b0);
    model(4, 4, 60, 0);
    pat = '1;
    for (j = 0; j < 40; j++) pat[1+j] = (j < 4) ? 1'b0 : (j >= 36) ? 1'b1 : (((j / 4) % 2) == 1);
    tests_run++;
    if (got_line[59:0] !== pat[59:0]) begin tests_failed++; $display("FAIL single55_wave got=%h exp=%h", got_line[59:0], pat[59:0]); end
    tests_run++;
    if (got_pulse !== (MAXC'(1) << 40)) begin tests_failed++; $display("FAIL single55_pulse got=%h exp=bit40", got_pulse[59:0]); end
    tests_run++;
    if (got_pb[7:0] !== 8'h55) begin tests_failed++; $display("FAIL single55_bits got=%h exp=55", got_pb[7:0]); end
    tests_run++;
    if (got_busy[41:40] !== 2'b01) begin tests_failed++; $display("FAIL single55_busy_drop got=%b exp=01", got_busy[41:40]); end
    tests_run++;
    if (got_line !== exp_line) begin tests_failed++; $display("FAIL single55_line got=%h exp=%h", got_line[59:0], exp_line[59:0]); end
  endtask

  task automatic test_back_to_back();
    int same;
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run(0, 260, 0, 1'b0);
    model(4, 4, 260, 0);
    same = 0;
    foreach (acc_k[i]) foreach (pop_k[j]) if (acc_k[i] == pop_k[j]) same++;
    tests_run++;
    if (got_line !== exp_line) begin tests_failed++; $display("FAIL b2b_line got=%h exp=%h", got_line[259:0], exp_line[259:0]); end
    tests_run++;
    if (got_ready !== exp_ready) begin tests_failed++; $display("FAIL b2b_ready got=%h exp=%h", got_ready[259:0], exp_ready[259:0]); end
    tests_run++;
    if (got_busy !== exp_busy) begin tests_failed++; $display("FAIL b2b_busy got=%h exp=%h", got_busy[259:0], exp_busy[259:0]); end
    tests_run++;
    if (got_pb[47:0] !== 48'h010203040506) begin tests_failed++; $display("FAIL b2b_order got=%h exp=010203040506", got_pb[47:0]); end
    tests_run++;
    if ($countones(got_pulse) != 6 || got_pulse !== exp_pulse) begin
      tests_failed++; $display("FAIL b2b_pulses got=%h exp=%h", got_pulse[259:0], exp_pulse[259:0]);
    end
    tests_run++;
    if (same < 1 || (&got_ready[259:0])) begin tests_failed++; $display("FAIL b2b_full_pushpop same_edge=%0d ready=%h", same, got_ready[259:0]); end
  endtask

  task automatic test_reset_mid_frame();
    src_q = '{8'hA3, 8'h3C};
    run(0, 60, 19, 1'b0);
    model(4, 4, 60, 19);
    tests_run++;
    if (got_line !== exp_line || got_line[59:18] !== '1) begin tests_failed++; $display("FAIL rst_mid_line got=%h exp=%h", got_line[59:0], exp_line[59:0]); end
    tests_run++;
    if (got_pulse !== '0) begin tests_failed++; $display("FAIL rst_mid_pulse got=%h exp=0", got_pulse[59:0]); end
    tests_run++;
    if (got_busy !== exp_busy || got_ready !== exp_ready) begin
      tests_failed++; $display("FAIL rst_mid_flags busy=%h exp=%h ready=%h exp=%h", got_busy[59:0], exp_busy[59:0], got_ready[59:0], exp_ready[59:0]);
    end
    src_q = '{8'h0F};
    run(0, 60, 0, 1'b0);
    model(4, 4, 60, 0);
    tests_run++;
    if (got_line !== exp_line) begin tests_failed++; $display("FAIL rst_after_line got=%h exp=%h", got_line[59:0], exp_line[59:0]); end
    tests_run++;
    if ($countones(got_pulse) != 1 || got_pb[7:0] !== 8'h0F) begin
      tests_failed++; $display("FAIL rst_after_bytes got=%h pulses=%0d exp=0f x1", got_pb[15:0], $countones(got_pulse));
    end
  endtask

  task automatic test_div1();
    src_q = '{8'hFF, 8'h00};
    run(1, 30, 0, 1'b0);
    model(1, 2, 30, 0);
    tests_run++;
    if (got_line[20:1] !== 20'b1_000000000_111111111_0) begin
      tests_failed++; $display("FAIL div1_wave got=%b exp=%b", got_line[20:1], 20'b1_000000000_111111111_0);
    end
    tests_run++;
    if (got_pulse !== ((MAXC'(1) << 10) | (MAXC'(1) << 20))) begin tests_failed++; $display("FAIL div1_pulse got=%h exp=bits 10,20", got_pulse[29:0]); end
    tests_run++;
    if (got_pb[15:0] !== 16'hFF00) begin tests_failed++; $display("FAIL div1_bytes got=%h exp=ff00", got_pb[15:0]); end
    tests_run++;
    if (got_line !== exp_line || got_busy !== exp_busy) begin
      tests_failed++; $display("FAIL div1_model line=%h exp=%h busy=%h exp=%h", got_line[29:0], exp_line[29:0], got_busy[29:0], exp_busy[29:0]);
    end
  endtask

  task automatic test_random();
    int n, nc;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(0, 255)));
      nc = n * 40 + 60;
      run(0, nc, 0, 1'b1);
      model(4, 4, nc, 0);
      tests_run++;
      if (got_line !== exp_line) begin tests_failed++; $display("FAIL rand%0d_line got=%h exp=%h", it, got_line[299:0], exp_line[299:0]); end
      tests_run++;
      if (got_pulse !== exp_pulse || got_pb !== exp_pb) begin
        tests_failed++; $display("FAIL rand%0d_pulses got=%h exp=%h", it, got_pb, exp_pb);
      end
      tests_run++;
      if (got_busy !== exp_busy || got_ready !== exp_ready) begin
        tests_failed++; $display("FAIL rand%0d_flags busy=%h exp=%h ready=%h exp=%h", it, got_busy[239:0], exp_busy[239:0], got_ready[239:0], exp_ready[239:0]);
      end
    end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    test_reset();
    test_idle();
    test_single_55();
    test_back_to_back();
    test_reset_mid_frame();
    test_div1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
- REQ-001: The block SHALL have parameter DIV, default 4, giving clock cycles per UART bit (legal range 1..65535).
- REQ-002: The block SHALL have parameter DEPTH, default 4, giving the byte FIFO depth (power of two, 2 or more).
- REQ-003: clock  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  synchronous reset, active-high.
- REQ-005: io_in_valid  input  1  producer offers a byte.
- REQ-006: io_in_ready  output  1  block can accept a byte this cycle.
- REQ-007: io_in_bits  input  8  byte to transmit.
- REQ-008: io_txd  output  1  serial line, 8N1, idle high, registered.
- REQ-009: io_busy  output  1  FIFO non-empty or frame in progress.
- REQ-010: io_txData_valid  output  1  one-cycle pulse when a frame's stop bit completes.
- REQ-011: io_txData_bits  output  8  byte just completed; valid only with io_txData_valid.

Function
- REQ-012: A byte SHALL be accepted on any rising edge where io_in_valid and io_in_ready are both 1.
- REQ-013: io_in_ready SHALL equal !full; it SHALL NOT depend on a same-cycle pop, so there is no push-when-full even if a pop coincides.
- REQ-014: Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged and preserve order.
- REQ-015: FIFO pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
- REQ-016: The FSM SHALL have the states IDLE, START, DATA and STOP.
- REQ-017: IDLE: io_txd=1; if the FIFO is non-empty, the FSM SHALL pop the head into the shift register, clear the baud counter and bit index, and go to START.
- REQ-018: START: io_txd=0 for exactly DIV cycles, then go to DATA.
- REQ-019: DATA: 8 bits SHALL be sent LSB first, each held for exactly DIV cycles; after bit 7 the FSM SHALL go to STOP.
- REQ-020: STOP: io_txd=1 for exactly DIV cycles.
- REQ-021: On the last STOP cycle, io_txData_valid SHALL pulse for 1 cycle with io_txData_bits equal to the transmitted byte.
- REQ-022: At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START directly (no idle bit between frames); otherwise it SHALL go to IDLE.
- REQ-023: A frame SHALL occupy exactly 10*DIV cycles.
- REQ-024: A byte accepted at edge t into an empty, idle block SHALL drive io_txd low starting with the cycle after edge t+1.
- REQ-025: The baud counter SHALL count 0..DIV-1 and wrap; with DIV=1 every bit lasts 1 cycle.
- REQ-026: io_busy SHALL be 1 whenever the state is not IDLE or the FIFO count is non-zero.
- REQ-027: Bytes SHALL be transmitted in acceptance order with none lost or duplicated.

Reset
- REQ-028: While reset=1 at an edge: state IDLE, FIFO emptied, counters 0, io_txd=1, io_in_ready=1, io_busy=0, io_txData_valid=0, io_txData_bits=0.
- REQ-029: Reset mid-frame SHALL abort the frame: io_txd is high from the next cycle, no io_txData_valid pulse occurs, and queued bytes are discarded.
- REQ-030: Inputs during reset SHALL be ignored; no byte is accepted at a reset edge.

Verification
- REQ-031: Reset released, no input -> io_txd=1, io_in_ready=1, io_busy=0, no io_txData_valid for 100 cycles.
- REQ-032: DIV=4, push 0x55 -> io_txd = 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles); io_txData_valid pulses once with 0x55 on the 40th frame cycle; io_busy drops the next cycle.
- REQ-033: DEPTH=4, io_in_valid held high with 0x01..0x06 -> io_in_ready drops when full and re-rises after each pop; the line carries 0x01..0x06 in order, back-to-back, 40 cycles per frame; six pulses occur.
- REQ-034: Push 0xA3 and 0x3C, assert reset for 1 cycle at frame cycle 17 -> io_txd=1 from the next cycle, no pulse, io_busy=0, FIFO empty; pushing 0x0F afterwards transmits only 0x0F.
- REQ-035: DIV=1, push 0xFF and 0x00 back-to-back -> 20 cycles total: 0,11111111,1,0,00000000,1; pulses at cycles 10 and 20 carry 0xFF and 0x00.
- REQ-036: With DEPTH-1 bytes queued and a pop edge, hold io_in_valid -> the push and pop at the same edge leave the count unchanged, and the order check passes.
